// File: rtl/tcm_dual_port_ram_if.sv
// Core-side bus into the tightly-coupled memory: one fetch port and one load/store port.
// The RAM takes the slave view; a core or testbench drives the master view.
interface tcm_dual_port_ram_if;
    // Fetch port
    logic        mem_i_rd_i;
    logic        mem_i_flush_i;
    logic        mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o;
    logic        mem_i_valid_o;
    logic        mem_i_error_o;
    logic [31:0] mem_i_inst_o;

    // Load/store port
    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i;
    logic        mem_d_writeback_i;
    logic        mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    modport slave (
        input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
               mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
               mem_d_writeback_i, mem_d_flush_i,
        output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
               mem_d_resp_tag_o
    );

    modport master (
        output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
               mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
               mem_d_writeback_i, mem_d_flush_i,
        input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
               mem_d_resp_tag_o
    );
endinterface

// File: rtl/tcm_dual_port_ram.sv
// Dual-port TCM for an RV32 core: a never-stalling fetch port and a load/store port
// sharing one word array, both answering exactly one cycle after the request.

// Shared word array. Reads are combinational so the registered outputs in the
// wrapper capture the pre-write word on the same edge (read-before-write).
module tcm_ram_array #(
    parameter int MEM_WORDS = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic [3:0]        wr_be,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] ra_idx,
    output logic [31:0]       ra_data,
    input  logic [ADDR_W-1:0] rb_idx,
    output logic [31:0]       rb_data
);
    // No reset: contents are architectural state and left unconstrained.
    logic [31:0] ram [0:MEM_WORDS-1];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_be[k])
                ram[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
    end

    assign ra_data = ram[ra_idx];
    assign rb_data = ram[rb_idx];
endmodule

module tcm_dual_port_ram #(
    parameter int MEM_WORDS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    tcm_dual_port_ram_if.slave   mem
);
    localparam int ADDR_W = $clog2(MEM_WORDS);

    typedef struct packed {
        logic        ack;
        logic [10:0] tag;
        logic [31:0] data;
    } d_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
    } i_resp_t;

    logic [ADDR_W-1:0] i_idx;
    logic [ADDR_W-1:0] d_idx;
    logic [31:0]       i_rdata;
    logic [31:0]       d_rdata;
    logic [3:0]        wr_be;
    logic              d_req;
    i_resp_t           i_resp_q;
    d_resp_t           d_resp_q;

    // Upper and byte-offset address bits are dropped, so addresses alias
    // modulo the array size.
    assign i_idx = mem.mem_i_pc_i[ADDR_W+1:2];
    assign d_idx = mem.mem_d_addr_i[ADDR_W+1:2];

    // Maintenance requests have nothing to maintain but must still be acked.
    assign d_req = mem.mem_d_rd_i | (|mem.mem_d_wr_i) | mem.mem_d_flush_i
                 | mem.mem_d_invalidate_i | mem.mem_d_writeback_i;

    assign wr_be = rst ? 4'b0000 : mem.mem_d_wr_i;

    tcm_ram_array #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_be   (wr_be),
        .wr_idx  (d_idx),
        .wr_data (mem.mem_d_data_wr_i),
        .ra_idx  (i_idx),
        .ra_data (i_rdata),
        .rb_idx  (d_idx),
        .rb_data (d_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_resp_q <= '0;
            d_resp_q <= '0;
        end else begin
            i_resp_q.valid <= mem.mem_i_rd_i;
            if (mem.mem_i_rd_i)
                i_resp_q.inst <= i_rdata;
            d_resp_q.ack <= d_req;
            if (d_req) begin
                d_resp_q.tag  <= mem.mem_d_req_tag_i;
                d_resp_q.data <= d_rdata;
            end
        end
    end

    assign mem.mem_i_accept_o   = 1'b1;
    assign mem.mem_i_error_o    = 1'b0;
    assign mem.mem_i_valid_o    = i_resp_q.valid;
    assign mem.mem_i_inst_o     = i_resp_q.inst;

    assign mem.mem_d_accept_o   = 1'b1;
    assign mem.mem_d_error_o    = 1'b0;
    assign mem.mem_d_ack_o      = d_resp_q.ack;
    assign mem.mem_d_data_rd_o  = d_resp_q.data;
    assign mem.mem_d_resp_tag_o = d_resp_q.tag;

    logic unused_bits;
    assign unused_bits = ^{mem.mem_i_flush_i, mem.mem_i_invalidate_i, mem.mem_d_cacheable_i,
                           mem.mem_i_pc_i[31:ADDR_W+2], mem.mem_i_pc_i[1:0],
                           mem.mem_d_addr_i[31:ADDR_W+2], mem.mem_d_addr_i[1:0]};
endmodule

// File: tb/tb_tcm_dual_port_ram.sv
// Scoreboarded bench for tcm_dual_port_ram: a word-array model predicts each response
// when the request is driven; a monitor pops and compares whenever outputs are due.
module tb_tcm_dual_port_ram;
    localparam int MEM_WORDS = 32;
    localparam int AW        = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcm_dual_port_ram_if bus();

    tcm_dual_port_ram #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .mem (bus.slave)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          chk;
        logic [10:0] tag;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    logic [31:0] model [MEM_WORDS];
    bit          known [MEM_WORDS];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One request cycle: drive at the falling edge, predict from the model, then
    // apply any store to the model (the response sees the pre-store word).
    task automatic drive(input bit ird, input logic [31:0] pc,
                         input bit drd, input logic [3:0] dwr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [10:0] tag,
                         input bit fl, input bit inv, input bit wb, input bit r);
        exp_t e;
        int ii, di;
        @(negedge clk);
        rst                    = r;
        bus.mem_i_rd_i         = ird;
        bus.mem_i_pc_i         = pc;
        bus.mem_i_flush_i      = 1'($urandom_range(0, 1));
        bus.mem_i_invalidate_i = 1'($urandom_range(0, 1));
        bus.mem_d_rd_i         = drd;
        bus.mem_d_wr_i         = dwr;
        bus.mem_d_addr_i       = addr;
        bus.mem_d_data_wr_i    = wdata;
        bus.mem_d_req_tag_i    = tag;
        bus.mem_d_flush_i      = fl;
        bus.mem_d_invalidate_i = inv;
        bus.mem_d_writeback_i  = wb;
        bus.mem_d_cacheable_i  = 1'($urandom_range(0, 1));
        ii = int'(pc[AW+1:2]);
        di = int'(addr[AW+1:2]);
        if (!r && ird) begin
            e.due = cyc + 1; e.data = model[ii]; e.chk = known[ii]; e.tag = '0;
            iq.push_back(e);
        end
        if (!r && (drd || dwr != 4'b0 || fl || inv || wb)) begin
            e.due = cyc + 1; e.data = model[di]; e.chk = known[di]; e.tag = tag;
            dq.push_back(e);
        end
        if (!r) begin
            for (int k = 0; k < 4; k++)
                if (dwr[k]) model[di][8*k +: 8] = wdata[8*k +: 8];
            if (dwr == 4'hF) known[di] = 1'b1;
        end
    endtask

    task automatic idle(input bit r);
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 11'h0, 0, 0, 0, r);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [10:0] t);
        drive(0, 32'h0, 0, be, a, d, t, 0, 0, 0, 0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [10:0] t);
        drive(0, 32'h0, 1, 4'h0, a, 32'h0, t, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        drive(1, pc, 0, 4'h0, 32'h0, 32'h0, 11'h0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle, after the edge has settled.
    logic [31:0] last_inst = '0;
    logic [31:0] last_d    = '0;
    logic [10:0] last_tag  = '0;
    bit          last_i_known = 1'b1;
    bit          last_d_known = 1'b1;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("const_accept_error",
                  {60'h0, bus.mem_i_accept_o, bus.mem_d_accept_o, bus.mem_i_error_o, bus.mem_d_error_o},
                  {60'h0, 4'b1100});
            if (rst) begin
                check("reset_i", {31'h0, bus.mem_i_valid_o, bus.mem_i_inst_o}, 64'h0);
                check("reset_d", {20'h0, bus.mem_d_ack_o, bus.mem_d_resp_tag_o, bus.mem_d_data_rd_o}, 64'h0);
                last_inst = '0; last_d = '0; last_tag = '0;
                last_i_known = 1'b1; last_d_known = 1'b1;
            end else begin
                while (iq.size() > 0 && iq[0].due < cyc) begin
                    e = iq.pop_front();
                    check("i_overdue", 64'(cyc), 64'(e.due));
                end
                if (iq.size() > 0 && iq[0].due == cyc) begin
                    e = iq.pop_front();
                    check("i_valid", 64'(bus.mem_i_valid_o), 64'h1);
                    if (e.chk) check("i_inst", 64'(bus.mem_i_inst_o), 64'(e.data));
                    last_inst = e.data; last_i_known = e.chk;
                end else begin
                    check("i_valid_idle", 64'(bus.mem_i_valid_o), 64'h0);
                    if (last_i_known) check("i_inst_hold", 64'(bus.mem_i_inst_o), 64'(last_inst));
                end

                while (dq.size() > 0 && dq[0].due < cyc) begin
                    e = dq.pop_front();
                    check("d_overdue", 64'(cyc), 64'(e.due));
                end
                if (dq.size() > 0 && dq[0].due == cyc) begin
                    e = dq.pop_front();
                    check("d_ack", 64'(bus.mem_d_ack_o), 64'h1);
                    check("d_tag", 64'(bus.mem_d_resp_tag_o), 64'(e.tag));
                    if (e.chk) check("d_data", 64'(bus.mem_d_data_rd_o), 64'(e.data));
                    last_d = e.data; last_d_known = e.chk; last_tag = e.tag;
                end else begin
                    check("d_ack_idle", 64'(bus.mem_d_ack_o), 64'h0);
                    check("d_tag_hold", 64'(bus.mem_d_resp_tag_o), 64'(last_tag));
                    if (last_d_known) check("d_data_hold", 64'(bus.mem_d_data_rd_o), 64'(last_d));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            model[i] = '0;
            known[i] = 1'b0;
        end

        // Reset held with requests on both ports: nothing may come back.
        for (int i = 0; i < 3; i++)
            drive(1, 32'h0, 1, 4'h0, 32'h8, 32'h0, 11'h7FF, 0, 0, 0, 1);
        // First request right at release.
        drive(1, 32'h4, 1, 4'h0, 32'h4, 32'h0, 11'h033, 0, 0, 0, 0);

        // Fill every word so later reads have a defined expectation.
        for (int i = 0; i < MEM_WORDS; i++)
            st(32'(i * 4), $urandom, 4'hF, 11'(i));

        // Full store then load.
        st(32'h8, 32'hDEADBEEF, 4'hF, 11'h155);
        ld(32'h8, 11'h2AA);

        // Byte enables.
        st(32'h10, 32'h11223344, 4'hF, 11'h001);
        st(32'h10, 32'hAABBCCDD, 4'b0100, 11'h002);
        ld(32'h10, 11'h003);

        // Fetch after store, then back-to-back fetches.
        st(32'h10, 32'h02C5D533, 4'hF, 11'h004);
        fetch(32'h10);
        fetch(32'h10);
        fetch(32'h14);
        idle(0);

        // Same-edge fetch and store to word 0: fetch sees the old word.
        drive(1, 32'h0, 0, 4'hF, 32'h0, 32'h12345678, 11'h005, 0, 0, 0, 0);
        fetch(32'h0);

        // Load and store together: old word back, single ack.
        drive(0, 32'h0, 1, 4'hF, 32'hC, 32'hCAFEF00D, 11'h006, 0, 0, 0, 0);
        ld(32'hC, 11'h007);

        // Aliasing and maintenance-only requests.
        ld(32'(MEM_WORDS * 4 + 8), 11'h008);
        drive(0, 32'h0, 0, 4'h0, 32'h8, 32'hFFFFFFFF, 11'h009, 1, 0, 0, 0);
        drive(0, 32'h0, 0, 4'h0, 32'h8, 32'hFFFFFFFF, 11'h00A, 0, 1, 0, 0);
        drive(0, 32'h0, 0, 4'h0, 32'h8, 32'hFFFFFFFF, 11'h00B, 0, 0, 1, 0);
        ld(32'h8, 11'h00C);

        // Reset mid-operation with stores that must be suppressed.
        st(32'h18, 32'h55AA55AA, 4'hF, 11'h00D);
        drive(1, 32'h18, 1, 4'hF, 32'h18, 32'h0BADBAD0, 11'h00E, 0, 0, 0, 1);
        drive(1, 32'h1C, 0, 4'hF, 32'h1C, 32'h0BADBAD1, 11'h00F, 0, 0, 0, 1);
        ld(32'h18, 11'h010);
        ld(32'h1C, 11'h011);

        // Randomized traffic, including aliased addresses and rare resets.
        for (int n = 0; n < 800; n++) begin
            logic [3:0] be;
            be = ($urandom_range(0, 2) == 0) ? 4'(($urandom)) : 4'h0;
            drive(1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), be, $urandom, $urandom, 11'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
        end

        idle(0);
        idle(0);
        idle(0);
        check("iq_drained", 64'(iq.size()), 64'h0);
        check("dq_drained", 64'(dq.size()), 64'h0);
        for (int i = 0; i < MEM_WORDS; i++)
            if (known[i]) check("ram_contents", 64'(dut.u_ram.ram[i]), 64'(model[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tcm_dual_port_ram.md
Name: tcm_dual_port_ram

Overview:
- Tightly-coupled memory for a single-issue RV32 core (RV32IM, mul/div in the execute stage).
- Two ports into one shared word array:
  - instruction-fetch port (I-port)
  - load/store port (D-port)
- Both ports are always ready. Each returns its response exactly one cycle after the request.
- The word array must be reachable by hierarchical reference, so formal benches can compare architectural memory.

Parameters:
- MEM_WORDS, default 32: number of 32-bit words. Must be a power of two, at least 2.
- ADDR_W, default clog2(MEM_WORDS): derived local value; word-index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_i_rd_i  in  1  fetch request
- mem_i_flush_i  in  1  fetch-side flush (no effect)
- mem_i_invalidate_i  in  1  fetch-side invalidate (no effect)
- mem_i_pc_i  in  32  fetch byte address
- mem_i_accept_o  out  1  fetch request accepted
- mem_i_valid_o  out  1  fetch response valid
- mem_i_error_o  out  1  fetch bus error
- mem_i_inst_o  out  32  fetched instruction
- mem_d_addr_i  in  32  data byte address
- mem_d_data_wr_i  in  32  store data
- mem_d_rd_i  in  1  load request
- mem_d_wr_i  in  4  byte write enables
- mem_d_cacheable_i  in  1  ignored
- mem_d_req_tag_i  in  11  request tag
- mem_d_invalidate_i  in  1  maintenance request
- mem_d_writeback_i  in  1  maintenance request
- mem_d_flush_i  in  1  maintenance request
- mem_d_data_rd_o  out  32  load data
- mem_d_accept_o  out  1  data request accepted
- mem_d_ack_o  out  1  data response
- mem_d_error_o  out  1  data bus error
- mem_d_resp_tag_o  out  11  echoed tag

Behaviour:
- Storage:
  - Array ram[0:MEM_WORDS-1] of 32 bits, instance-visible (sub-instance u_ram, array named ram).
  - Not cleared by reset. Initial contents are undefined (unconstrained for formal).
- Addressing:
  - Word index = addr[ADDR_W+1:2] on both ports.
  - Upper address bits and addr[1:0] are ignored, so addresses alias modulo MEM_WORDS*4.
- Constant outputs:
  - mem_i_accept_o = 1 and mem_d_accept_o = 1 at all times, including during reset.
  - mem_i_error_o = 0 and mem_d_error_o = 0 at all times.
- Reset (async, rst=1): mem_i_valid_o=0, mem_i_inst_o=0, mem_d_ack_o=0, mem_d_data_rd_o=0, mem_d_resp_tag_o=0.
- I-port:
  - If mem_i_rd_i is high at edge N, then at N+1: mem_i_valid_o=1 and mem_i_inst_o = ram[index(pc)] as read at edge N.
  - mem_i_valid_o is a 1-cycle pulse per request.
  - Back-to-back requests give back-to-back valids.
  - When no request is made, valid=0 and inst holds its last value.
  - Flush/invalidate produce no response and no state change.
- D-port request:
  - A request = mem_d_rd_i, any bit of mem_d_wr_i, mem_d_flush_i, mem_d_invalidate_i, or mem_d_writeback_i.
  - For a request at edge N, at N+1: mem_d_ack_o=1 (1-cycle pulse) and mem_d_resp_tag_o = req_tag sampled at N.
- D-port write: at edge N, ram[index] byte k is updated with data_wr[8k+7:8k] for each k where wr[k]=1. Other bytes are unchanged.
- D-port read:
  - mem_d_data_rd_o at N+1 = ram[index] before any same-edge write (read-before-write).
  - Loaded on any D request; holds otherwise.
  - Byte/halfword extraction is done by the core, not by this block.
- Simultaneous access:
  - rd and wr in the same cycle: write is performed; data_rd returns the old word; a single ack.
  - I-fetch and D-write to the same word on the same edge: the fetch returns the old word; the new value is visible from the next fetch.
- Reset mid-operation: pending ack/valid are dropped; no response is produced for a request sampled while rst=1. Writes are suppressed while rst=1.
- The core uses this block for a 1-cycle fetch, so the I-port must never stall.

Test Plan:
- Reset: hold rst with rd requests on both ports -> valid=0, ack=0, accept=1, error=0; after release, first response appears 1 cycle after the first request.
- Full store then load: wr=4'hF, addr=0x8, data=0xDEADBEEF, tag=0x155; next cycle rd addr 0x8, tag 0x2AA:
  - store: ack at N+1 with resp_tag=0x155
  - load: ack with data_rd=0xDEADBEEF, resp_tag=0x2AA
- Byte enables: preload word 4 with 0x11223344, then wr=4'b0100, data=0xAABBCCDD -> word reads back 0x11BB3344.
- Fetch after store: store 0x02C5D533 at addr 0x10, then mem_i_rd with pc=0x10 -> valid=1 and inst=0x02C5D533 one cycle later; back-to-back fetches at 0x10 and 0x14 give valid on 2 consecutive cycles.
- Same-edge conflict: fetch pc=0x0 while storing 0x12345678 to addr 0x0 -> inst = old word; the following fetch = 0x12345678.
- Aliasing and maintenance:
  - rd addr = MEM_WORDS*4+8 -> returns word 2.
  - flush alone -> ack with echoed tag, memory unchanged.
